// File: rtl/snake_clk_seg.sv
// snake_clk_seg -- clock division and two-digit score display for the snake game.
//
// Purpose:
//   - CLK_div       : game-tick clock, half-period = max(speed_control,1) CLK cycles,
//                     programmable at runtime so the game can speed up.
//   - CLK_div1000HZ : scan clock, half-period SCAN_HALF = CLK_FREQ_HZ/(2*SCAN_HZ) (min 1).
//   - COM/bcd_out/SEG : two-digit BCD score multiplexed onto one active-low
//                     seven-segment bus; digit swaps on every scan-clock rise.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-high reset
//   speed_control  in   [31:0] game-tick half-period in CLK cycles (0 treated as 1)
//   score          in   [3:0] ones digit, BCD
//   tens_score     in   [3:0] tens digit, BCD
//   CLK_div        out  game-tick clock, 50% duty
//   CLK_div1000HZ  out  scan clock, 50% duty
//   COM            out  [1:0] active-low digit select: 2'b10 ones, 2'b01 tens
//   bcd_out        out  [3:0] digit currently shown
//   SEG            out  [7:0] active-low segments, SEG[0..6]=a..g, SEG[7]=dp (always off)
//
// Build option:
//   SEG_BLANK_LEAD_ZERO_EN - when defined, a tens digit of 0 is blanked (SEG=8'hFF)
//                            while the tens slot is selected; COM keeps cycling.

module snake_clk_seg #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_HZ     = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] speed_control,
    input  logic [3:0]  score,
    input  logic [3:0]  tens_score,
    output logic        CLK_div,
    output logic        CLK_div1000HZ,
    output logic [1:0]  COM,
    output logic [3:0]  bcd_out,
    output logic [7:0]  SEG
);

    localparam int SCAN_RAW  = CLK_FREQ_HZ / (2 * SCAN_HZ);
    localparam int SCAN_HALF = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
    localparam logic [31:0] SCAN_LIM = 32'(SCAN_HALF - 1);

    localparam logic [1:0] COM_ONES = 2'b10;
    localparam logic [1:0] COM_TENS = 2'b01;

    logic [31:0] tcnt;
    logic [31:0] tick_lim;
    logic [31:0] scnt;
    logic        scan_wrap;
    logic        dsel;
    logic        dsel_nxt;

    // speed_control of 0 behaves like 1: toggle every cycle.
    assign tick_lim = (speed_control == 32'd0) ? 32'd0 : speed_control - 32'd1;

    // >= rather than == so lowering speed_control below the running count
    // toggles on the next edge instead of waiting for a 32-bit wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt    <= 32'd0;
            CLK_div <= 1'b0;
        end else if (tcnt >= tick_lim) begin
            tcnt    <= 32'd0;
            CLK_div <= ~CLK_div;
        end else begin
            tcnt    <= tcnt + 32'd1;
        end
    end

    assign scan_wrap = (scnt >= SCAN_LIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scnt          <= 32'd0;
            CLK_div1000HZ <= 1'b0;
        end else if (scan_wrap) begin
            scnt          <= 32'd0;
            CLK_div1000HZ <= ~CLK_div1000HZ;
        end else begin
            scnt          <= scnt + 32'd1;
        end
    end

    // Digit swaps on the edge where the scan clock goes 0->1, so each digit
    // stays lit for one full scan period. COM is loaded from the next dsel
    // so it moves on that same edge, in step with bcd_out.
    assign dsel_nxt = (scan_wrap && !CLK_div1000HZ) ? ~dsel : dsel;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsel <= 1'b0;
            COM  <= COM_ONES;
        end else begin
            dsel <= dsel_nxt;
            COM  <= dsel_nxt ? COM_TENS : COM_ONES;
        end
    end

    assign bcd_out = dsel ? tens_score : score;

    always_comb begin
        SEG = 8'hFF;
        case (bcd_out)
            4'd0:    SEG = 8'hC0;
            4'd1:    SEG = 8'hF9;
            4'd2:    SEG = 8'hA4;
            4'd3:    SEG = 8'hB0;
            4'd4:    SEG = 8'h99;
            4'd5:    SEG = 8'h92;
            4'd6:    SEG = 8'h82;
            4'd7:    SEG = 8'hF8;
            4'd8:    SEG = 8'h80;
            4'd9:    SEG = 8'h90;
            default: SEG = 8'hFF;
        endcase
`ifdef SEG_BLANK_LEAD_ZERO_EN
        if (dsel && (tens_score == 4'd0))
            SEG = 8'hFF;
`else
`endif
    end

endmodule

// File: tb/tb_snake_clk_seg.sv
module tb_snake_clk_seg;

    // SCAN_HALF = 8/(2*1) = 4
    localparam int H = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] speed_control;
    logic [3:0]  score;
    logic [3:0]  tens_score;
    logic        CLK_div;
    logic        CLK_div1000HZ;
    logic [1:0]  COM;
    logic [3:0]  bcd_out;
    logic [7:0]  SEG;

    int cmp_cnt = 0;
    int err_cnt = 0;

    snake_clk_seg #(.CLK_FREQ_HZ(8), .SCAN_HZ(1)) dut (
        .CLK(CLK), .RST(RST), .speed_control(speed_control),
        .score(score), .tens_score(tens_score),
        .CLK_div(CLK_div), .CLK_div1000HZ(CLK_div1000HZ),
        .COM(COM), .bcd_out(bcd_out), .SEG(SEG)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] seg_of(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_k = edges since reset release; game tick tracked as
    // edges since the last toggle against the live half-period.
    int   m_k;
    int   m_since;
    logic m_div;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_k = 0; m_since = 0; m_div = 1'b0;
        end else begin
            m_k++;
            m_since++;
            if (m_since >= ((speed_control == 0) ? 1 : int'(speed_control))) begin
                m_div = ~m_div;
                m_since = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            logic       e_scan, e_dsel;
            logic [3:0] e_bcd;
            logic [7:0] e_seg;
            e_scan = ((m_k / H) % 2) == 1;
            e_dsel = (((m_k + H) / (2 * H)) % 2) == 1;
            e_bcd  = e_dsel ? tens_score : score;
            e_seg  = seg_of(int'(e_bcd));
`ifdef SEG_BLANK_LEAD_ZERO_EN
            if (e_dsel && tens_score == 4'd0) e_seg = 8'hFF;
`endif
            check("model_CLK_div", 32'(CLK_div), 32'(m_div));
            check("model_scan", 32'(CLK_div1000HZ), 32'(e_scan));
            check("model_COM", 32'(COM), e_dsel ? 32'h1 : 32'h2);
            check("model_bcd_out", 32'(bcd_out), 32'(e_bcd));
            check("model_SEG", 32'(SEG), 32'(e_seg));
        end
    end

    // After step(n) from release, n rising edges have occurred.
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_in();
        #1;
    endtask

    initial begin
        int guard;
        RST = 1'b1; speed_control = 32'd3; score = 4'd7; tens_score = 4'd2;
        repeat (3) @(negedge CLK);
        check("rst_CLK_div", 32'(CLK_div), 32'd0);
        check("rst_scan", 32'(CLK_div1000HZ), 32'd0);
        check("rst_COM", 32'(COM), 32'h2);
        check("rst_bcd", 32'(bcd_out), 32'd7);
        check("rst_SEG", 32'(SEG), 32'hF8);

        #1 RST = 1'b0;
        step(2); check("tick_k2", 32'(CLK_div), 32'd0);
        step(1); check("tick_k3", 32'(CLK_div), 32'd1);
        step(1);
        check("scan_k4", 32'(CLK_div1000HZ), 32'd1);
        check("com_k4", 32'(COM), 32'h1);
        check("bcd_k4", 32'(bcd_out), 32'd2);
        check("seg_k4", 32'(SEG), 32'hA4);
        step(2); check("tick_k6", 32'(CLK_div), 32'd0);
        step(6);
        check("com_k12", 32'(COM), 32'h2);
        check("bcd_k12", 32'(bcd_out), 32'd7);
        check("seg_k12", 32'(SEG), 32'hF8);
        check("tick_k12", 32'(CLK_div), 32'd0);

        set_in(); speed_control = 32'd1;
        step(1); check("sc1_k13", 32'(CLK_div), 32'd1);
        step(1); check("sc1_k14", 32'(CLK_div), 32'd0);

        set_in(); speed_control = 32'd100;
        step(50); check("sc100_k64", 32'(CLK_div), 32'd0);
        set_in(); speed_control = 32'd2;
        step(1); check("sc2_k65", 32'(CLK_div), 32'd1);

        // Decoder sweep: both digits equal so bcd_out == v in either slot.
        for (int v = 0; v < 16; v++) begin
            set_in(); score = 4'(v); tens_score = 4'(v);
            step(1);
`ifdef SEG_BLANK_LEAD_ZERO_EN
            if (v != 0) check("sweep_SEG", 32'(SEG), 32'(seg_of(v)));
`else
            check("sweep_SEG", 32'(SEG), 32'(seg_of(v)));
`endif
            check("sweep_bcd", 32'(bcd_out), 32'(v));
        end

        // Leading-zero behaviour.
        set_in(); score = 4'd5; tens_score = 4'd0;
        guard = 0;
        while (COM !== 2'b01 && guard < 20) begin step(1); guard++; end
        check("lz_tens_reached", 32'(guard < 20), 32'd1);
`ifdef SEG_BLANK_LEAD_ZERO_EN
        check("lz_tens_SEG", 32'(SEG), 32'hFF);
`else
        check("lz_tens_SEG", 32'(SEG), 32'hC0);
`endif
        guard = 0;
        while (COM !== 2'b10 && guard < 20) begin step(1); guard++; end
        check("lz_ones_reached", 32'(guard < 20), 32'd1);
        check("lz_ones_SEG", 32'(SEG), 32'h92);

        // Mid-count asynchronous reset.
        set_in(); speed_control = 32'd5; score = 4'd3; tens_score = 4'd8;
        step(7);
        @(posedge CLK); #3 RST = 1'b1;
        #1;
        check("mid_CLK_div", 32'(CLK_div), 32'd0);
        check("mid_scan", 32'(CLK_div1000HZ), 32'd0);
        check("mid_COM", 32'(COM), 32'h2);
        check("mid_bcd", 32'(bcd_out), 32'd3);
        check("mid_SEG", 32'(SEG), 32'hB0);
        step(2);
        #1 RST = 1'b0;
        step(4); check("mid_k4", 32'(CLK_div), 32'd0);
        step(1); check("mid_k5", 32'(CLK_div), 32'd1);
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
